iiitb_brg_prog: RTL and testbench

IIITB_BRG_PROG -- requirements
Module: iiitb_brg_prog

---
 rtl/iiitb_brg_prog.sv | 159 +++++++++++++++
 tb/tb_iiitb_brg_prog.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_brg_prog.sv
// Programmable UART baud-rate generator.
//
// Produces an oversample tick (OVS per bit), a one-per-bit baud tick and a
// 50%-duty square wave at the baud rate. Seven preset rates are derived from
// CLK_HZ when the design is built. sel = 3'b111 selects a run-time divisor
// taken from div_in.
//
// Ports:
//   clk        system clock, rising-edge active
//   reset      asynchronous, active-high
//   en         generator enable; low clears the counters and silences outputs
//   sel        rate select (000..110 presets, 111 = div_in)
//   div_in     programmable divisor, clamped to a minimum of 2
//   ovs_tick   one-cycle pulse at OVS x baud
//   baud_tick  one-cycle pulse once per bit period
//   clkout     registered square wave at the baud rate
//   cfg_ack    one-cycle pulse in the cycle after a new configuration takes effect
//
// A new rate request is held pending and only swapped in on a bit boundary
// (or immediately while disabled), so a bit period is never cut short or
// stretched.

module iiitb_brg_prog #(
  parameter int unsigned CLK_HZ = 125000000,
  parameter int unsigned OVS    = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       sel,
  input  logic [CNT_W-1:0] div_in,
  output logic             ovs_tick,
  output logic             baud_tick,
  output logic             clkout,
  output logic             cfg_ack
);

  localparam int unsigned PhW = (OVS > 1) ? $clog2(OVS) : 1;

  localparam logic [PhW-1:0] PhLast = PhW'(OVS - 1);
  localparam logic [PhW-1:0] PhHalf = PhW'(OVS / 2);

  localparam logic [2:0] SelProg = 3'b111;

  // Rounded divisor: (CLK_HZ + baud*OVS/2) / (baud*OVS), never below 2.
  function automatic logic [CNT_W-1:0] calc_div(input longint unsigned baud);
    longint unsigned clk_hz;
    longint unsigned ovs;
    longint unsigned den;
    longint unsigned quo;
    clk_hz = 64'(CLK_HZ);
    ovs    = 64'(OVS);
    den    = baud * ovs;
    quo    = (clk_hz + den / 64'd2) / den;
    if (quo < 64'd2) begin
      quo = 64'd2;
    end
    return quo[CNT_W-1:0];
  endfunction

  localparam logic [CNT_W-1:0] Div115200 = calc_div(64'd115200);
  localparam logic [CNT_W-1:0] Div57600  = calc_div(64'd57600);
  localparam logic [CNT_W-1:0] Div38400  = calc_div(64'd38400);
  localparam logic [CNT_W-1:0] Div19200  = calc_div(64'd19200);
  localparam logic [CNT_W-1:0] Div9600   = calc_div(64'd9600);
  localparam logic [CNT_W-1:0] Div4800   = calc_div(64'd4800);
  localparam logic [CNT_W-1:0] Div2400   = calc_div(64'd2400);

  localparam logic [CNT_W-1:0] DivMin = CNT_W'(2);

  // Active configuration and counters.
  logic [2:0]       sel_act_q, sel_act_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] ocnt_q, ocnt_d;
  logic [PhW-1:0]   ph_q, ph_d;
  logic             clkout_q, clkout_d;
  logic             cfg_ack_q, cfg_ack_d;

  logic [CNT_W-1:0] req_div;
  logic [CNT_W-1:0] div_last;
  logic             pending;
  logic             apply;

  // Divisor the current inputs are asking for.
  always_comb begin
    req_div = Div115200;
    case (sel)
      3'b000:  req_div = Div115200;
      3'b001:  req_div = Div57600;
      3'b010:  req_div = Div38400;
      3'b011:  req_div = Div19200;
      3'b100:  req_div = Div9600;
      3'b101:  req_div = Div4800;
      3'b110:  req_div = Div2400;
      default: req_div = (div_in < DivMin) ? DivMin : div_in;
    endcase
  end

  // For a preset sel the divisor is fixed, so the divisor compare only ever
  // fires on its own for sel = 111 with a changed div_in.
  assign pending = (sel != sel_act_q) || (sel == SelProg && req_div != div_act_q);

  // div_act is always >= 2, so this never underflows.
  assign div_last  = div_act_q - CNT_W'(1);
  assign ovs_tick  = en && (ocnt_q == div_last);
  assign baud_tick = ovs_tick && (ph_q == PhLast);

  // Swap only on a bit boundary while running; immediately while disabled.
  assign apply = pending && (!en || baud_tick);

  always_comb begin
    ocnt_d    = ocnt_q;
    ph_d      = ph_q;
    sel_act_d = sel_act_q;
    div_act_d = div_act_q;
    cfg_ack_d = apply;

    if (!en) begin
      ocnt_d = '0;
      ph_d   = '0;
    end else if (ovs_tick) begin
      ocnt_d = '0;
      ph_d   = (ph_q == PhLast) ? '0 : ph_q + PhW'(1);
    end else begin
      ocnt_d = ocnt_q + CNT_W'(1);
    end

    if (apply) begin
      sel_act_d = sel;
      div_act_d = req_div;
    end

    // Follows the phase being entered so clkout rises together with the wrap.
    clkout_d = en && (ph_d < PhHalf);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_act_q <= 3'b000;
      div_act_q <= Div115200;
      ocnt_q    <= '0;
      ph_q      <= '0;
      clkout_q  <= 1'b0;
      cfg_ack_q <= 1'b0;
    end else begin
      sel_act_q <= sel_act_d;
      div_act_q <= div_act_d;
      ocnt_q    <= ocnt_d;
      ph_q      <= ph_d;
      clkout_q  <= clkout_d;
      cfg_ack_q <= cfg_ack_d;
    end
  end

  assign clkout  = clkout_q;
  assign cfg_ack = cfg_ack_q;

endmodule

// File: tb/tb_iiitb_brg_prog.sv
// Directed bench for iiitb_brg_prog at default parameters (125 MHz, OVS=16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_iiitb_brg_prog;

  localparam int WOvs  = 0;
  localparam int WBaud = 1;
  localparam int WAck  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [2:0]  sel;
  logic [15:0] div_in;
  logic        ovs_tick;
  logic        baud_tick;
  logic        clkout;
  logic        cfg_ack;

  int n_cmp   = 0;
  int n_err   = 0;
  int ack_cnt = 0;

  always #5 clk = ~clk;

  iiitb_brg_prog dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .sel       (sel),
    .div_in    (div_in),
    .ovs_tick  (ovs_tick),
    .baud_tick (baud_tick),
    .clkout    (clkout),
    .cfg_ack   (cfg_ack)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One cycle: advance to the falling edge and tally any cfg_ack seen.
  task automatic sample();
    @(negedge clk);
    if (cfg_ack === 1'b1) ack_cnt++;
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) sample();
  endtask

  function automatic logic pick(input int which);
    case (which)
      WOvs:    return ovs_tick;
      WBaud:   return baud_tick;
      default: return cfg_ack;
    endcase
  endfunction

  // Cycles until the chosen output is seen high; -1 on timeout.
  task automatic wait_for(input int which, input int max_cyc, output int n);
    n = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      sample();
      if (pick(which) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic count_win(input int len, output int n_ovs, output int n_baud,
                           output int n_clk);
    n_ovs  = 0;
    n_baud = 0;
    n_clk  = 0;
    for (int i = 0; i < len; i++) begin
      sample();
      if (ovs_tick === 1'b1)  n_ovs++;
      if (baud_tick === 1'b1) n_baud++;
      if (clkout === 1'b1)    n_clk++;
    end
  endtask

  initial begin
    int n;
    int a0;
    int c_o;
    int c_b;
    int c_c;
    int quiet;

    reset  = 1'b1;
    en     = 1'b0;
    sel    = 3'b000;
    div_in = 16'd0;
    skip(2);
    check_eq("rst_ovs_tick",  int'(ovs_tick),  0);
    check_eq("rst_baud_tick", int'(baud_tick), 0);
    check_eq("rst_clkout",    int'(clkout),    0);
    check_eq("rst_cfg_ack",   int'(cfg_ack),   0);

    // 115200: divisor 68, bit = 1088 cycles.
    reset = 1'b0;
    en    = 1'b1;
    wait_for(WOvs, 200, n);
    check_eq("p0_first_ovs", n, 67);
    wait_for(WOvs, 200, n);
    check_eq("p0_ovs_period", n, 68);
    wait_for(WBaud, 3000, n);
    check_eq("p0_first_baud", n, 952);
    check_eq("p0_clk_low_at_baud", int'(clkout), 0);
    count_win(1088, c_o, c_b, c_c);
    check_eq("p0_win_ovs", c_o, 16);
    check_eq("p0_win_baud", c_b, 1);
    check_eq("p0_win_clk_high", c_c, 544);
    check_eq("p0_win_ends_baud", int'(baud_tick), 1);

    // Mid-bit switch to 9600: bit completes, then divisor 814.
    skip(500);
    a0  = ack_cnt;
    sel = 3'b100;
    wait_for(WBaud, 3000, n);
    check_eq("sw_bit_completes", n, 588);
    check_eq("sw_no_early_ack", ack_cnt - a0, 0);
    sample();
    check_eq("sw_ack_after_baud", int'(cfg_ack), 1);
    a0 = ack_cnt;
    wait_for(WOvs, 1000, n);
    check_eq("sw_first_ovs_814", n, 813);
    wait_for(WOvs, 1000, n);
    check_eq("sw_ovs_period_814", n, 814);
    check_eq("sw_ack_single", ack_cnt - a0, 0);

    // Pending request while running, then disable for 5 cycles.
    sel = 3'b000;
    a0  = ack_cnt;
    skip(3);
    check_eq("dis_no_ack_running", ack_cnt - a0, 0);
    en    = 1'b0;
    quiet = 0;
    for (int i = 0; i < 5; i++) begin
      sample();
      if (i == 0) check_eq("dis_ack_first_edge", int'(cfg_ack), 1);
      if (ovs_tick === 1'b1 || baud_tick === 1'b1 || clkout === 1'b1) quiet++;
    end
    check_eq("dis_outputs_low", quiet, 0);
    check_eq("dis_ack_count", ack_cnt - a0, 1);
    en = 1'b1;
    wait_for(WOvs, 200, n);
    check_eq("dis_reenable_first_ovs", n, 67);

    // 000 -> 011 -> 010 within one bit: one apply, divisor 203.
    wait_for(WBaud, 2000, n);
    check_eq("tg_align_baud", n, 1020);
    a0 = ack_cnt;
    skip(100);
    sel = 3'b011;
    skip(100);
    sel = 3'b010;
    wait_for(WBaud, 2000, n);
    check_eq("tg_bit_completes", n, 888);
    check_eq("tg_no_early_ack", ack_cnt - a0, 0);
    sample();
    check_eq("tg_ack_after_baud", int'(cfg_ack), 1);
    wait_for(WOvs, 500, n);
    check_eq("tg_first_ovs_203", n, 202);
    wait_for(WOvs, 500, n);
    check_eq("tg_ovs_period_203", n, 203);
    check_eq("tg_single_ack", ack_cnt - a0, 1);

    // Programmable divisor: div_in=1 clamps to 2, div_in=0 changes nothing.
    en     = 1'b0;
    sel    = 3'b111;
    div_in = 16'd1;
    sample();
    check_eq("pg_ack_disabled", int'(cfg_ack), 1);
    en = 1'b1;
    wait_for(WOvs, 10, n);
    check_eq("pg_first_ovs", n, 1);
    wait_for(WOvs, 10, n);
    check_eq("pg_ovs_period", n, 2);
    wait_for(WBaud, 100, n);
    check_eq("pg_first_baud", n, 28);
    wait_for(WBaud, 100, n);
    check_eq("pg_baud_period", n, 32);
    div_in = 16'd0;
    a0     = ack_cnt;
    count_win(64, c_o, c_b, c_c);
    check_eq("pg0_win_ovs", c_o, 32);
    check_eq("pg0_win_baud", c_b, 2);
    check_eq("pg0_no_ack", ack_cnt - a0, 0);

    // Request applied in the current baud_tick cycle, then async reset mid-bit.
    sel = 3'b100;
    wait_for(WAck, 100, n);
    check_eq("rs_apply_on_tick", n, 1);
    skip(300);
    check_eq("rs_clk_high_before", int'(clkout), 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rs_async_clkout", int'(clkout), 0);
    check_eq("rs_async_ovs", int'(ovs_tick), 0);
    check_eq("rs_async_baud", int'(baud_tick), 0);
    check_eq("rs_async_ack", int'(cfg_ack), 0);
    sample();
    reset = 1'b0;
    wait_for(WOvs, 200, n);
    check_eq("rs_div_back_to_68", n, 67);
    wait_for(WAck, 2000, n);
    check_eq("rs_pending_at_first_baud", n, 1021);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
